neuron_layer_scheduler: RTL and testbench

NEURON_LAYER_SCHEDULER -- requirements
Module: neuron_layer_scheduler

---
 rtl/neuron_layer_scheduler.sv | 132 +++++++++++++
 tb/tb_neuron_layer_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_scheduler.sv
// Runs one dense layer through a single shared neuron: fetch a weight row, run the neuron, store its result.
// Optional macro SCHED_RELU_EN clamps negative neuron results to zero before they are stored.
module neuron_layer_scheduler #(
    parameter int N  = 50,
    parameter int DW = 8,
    parameter int M  = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N*DW-1:0] in_vec,
    output logic            w_rd,
    output logic [7:0]      w_addr,
    input  logic [N*DW-1:0] w_data,
    output logic            nrn_start,
    output logic [N*DW-1:0] nrn_in_vec,
    output logic [N*DW-1:0] nrn_w_vec,
    input  logic [DW-1:0]   nrn_out,
    input  logic            nrn_done,
    output logic [M*DW-1:0] out_vec,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_W,
        START,
        RUN,
        STORE,
        DONE
    } state_t;

    localparam logic [7:0] LAST = 8'(M - 1);

    state_t        state;
    state_t        next_state;
    logic [7:0]    idx;
    logic [DW-1:0] result;
    logic [DW-1:0] store_val;

`ifdef SCHED_RELU_EN
    assign store_val = result[DW-1] ? '0 : result;
`else
    assign store_val = result;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        w_rd       = 1'b0;
        w_addr     = 8'd0;
        nrn_start  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                w_rd       = 1'b1;
                w_addr     = idx;
                next_state = WAIT_W;
            end
            WAIT_W: next_state = START;
            START: begin
                nrn_start  = 1'b1;
                next_state = RUN;
            end
            RUN: begin
                if (nrn_done) begin
                    next_state = STORE;
                end
            end
            STORE: next_state = (idx == LAST) ? DONE : FETCH;
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operands and results are only touched in the state that owns them, so stray inputs elsewhere are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= 8'd0;
            result     <= '0;
            nrn_in_vec <= '0;
            nrn_w_vec  <= '0;
            out_vec    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        nrn_in_vec <= in_vec;
                        idx        <= 8'd0;
                    end
                end
                WAIT_W: nrn_w_vec <= w_data;
                RUN: begin
                    if (nrn_done) begin
                        result <= nrn_out;
                    end
                end
                STORE: begin
                    for (int k = 0; k < M; k++) begin
                        if (idx == 8'(k)) begin
                            out_vec[k*DW +: DW] <= store_val;
                        end
                    end
                    if (idx != LAST) begin
                        idx <= idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Bench for neuron_layer_scheduler: an M=3 and an M=1 instance, each with a behavioural weight memory and neuron,
// checked against layer-level expectations (visit order, operands, latency, stored results, reset behaviour).
module tb_neuron_layer_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int NW = N * DW;
    localparam int MA = 3;
    localparam int MB = 1;

`ifdef SCHED_RELU_EN
    localparam logic [DW-1:0] F0_STORED = 8'h00;
`else
    localparam logic [DW-1:0] F0_STORED = 8'hF0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NW-1:0]    in_vec;
    logic [1:0]       start;
    logic [1:0]       spur;
    logic [1:0]       w_rd;
    logic [1:0]       nrn_start;
    logic [1:0]       busy;
    logic [1:0]       done;
    logic [1:0]       model_done;
    logic [1:0]       nrn_done;
    logic [7:0]       w_addr     [2];
    logic [NW-1:0]    w_data     [2];
    logic [NW-1:0]    nrn_in_vec [2];
    logic [NW-1:0]    nrn_w_vec  [2];
    logic [DW-1:0]    nrn_out    [2];
    logic [MA*DW-1:0] out_a;
    logic [MB*DW-1:0] out_b;

    logic [NW-1:0]    wmem [2][MA];
    logic [DW-1:0]    rtab [2][MA];
    int               lat  [2];
    int               ncnt [2];
    int               ridx [2];

    int               addr_q [$];
    logic [NW-1:0]    wv_q   [$];
    logic [NW-1:0]    iv_q   [$];
    int               wrd_cnt  [2];
    int               st_cnt   [2];
    int               done_cnt [2];

    int               checks = 0;
    int               passes = 0;
    int               fails  = 0;

    always #5 clk = ~clk;

    assign nrn_done = model_done | spur;

    neuron_layer_scheduler #(.N(N), .DW(DW), .M(MA)) u_dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .in_vec(in_vec),
        .w_rd(w_rd[0]), .w_addr(w_addr[0]), .w_data(w_data[0]),
        .nrn_start(nrn_start[0]), .nrn_in_vec(nrn_in_vec[0]), .nrn_w_vec(nrn_w_vec[0]),
        .nrn_out(nrn_out[0]), .nrn_done(nrn_done[0]),
        .out_vec(out_a), .busy(busy[0]), .done(done[0])
    );

    neuron_layer_scheduler #(.N(N), .DW(DW), .M(MB)) u_dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .in_vec(in_vec),
        .w_rd(w_rd[1]), .w_addr(w_addr[1]), .w_data(w_data[1]),
        .nrn_start(nrn_start[1]), .nrn_in_vec(nrn_in_vec[1]), .nrn_w_vec(nrn_w_vec[1]),
        .nrn_out(nrn_out[1]), .nrn_done(nrn_done[1]),
        .out_vec(out_b), .busy(busy[1]), .done(done[1])
    );

    // Weight memory answers one cycle after a read (noise otherwise); the neuron raises done lat cycles after its start.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            w_data[i] <= w_rd[i] ? wmem[i][w_addr[i][1:0]] : NW'($urandom);
            if (rst) begin
                ncnt[i]       <= 0;
                ridx[i]       <= 0;
                model_done[i] <= 1'b0;
                nrn_out[i]    <= '0;
            end else if (nrn_start[i]) begin
                ncnt[i]       <= lat[i];
                model_done[i] <= 1'b0;
                nrn_out[i]    <= DW'($urandom);
            end else if (ncnt[i] == 1) begin
                ncnt[i]       <= 0;
                model_done[i] <= 1'b1;
                nrn_out[i]    <= rtab[i][ridx[i]];
                ridx[i]       <= (ridx[i] + 1) % ((i == 0) ? MA : MB);
            end else begin
                model_done[i] <= 1'b0;
                nrn_out[i]    <= DW'($urandom);
                if (ncnt[i] > 1) ncnt[i] <= ncnt[i] - 1;
            end
        end
    end

    // Event recorder: weight reads, neuron starts (with operands) and done pulses.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_rd[i]) begin
                addr_q.push_back(int'(w_addr[i]));
                wrd_cnt[i] <= wrd_cnt[i] + 1;
            end
            if (nrn_start[i]) begin
                wv_q.push_back(nrn_w_vec[i]);
                iv_q.push_back(nrn_in_vec[i]);
                st_cnt[i] <= st_cnt[i] + 1;
            end
            if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef SCHED_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [MA*DW-1:0] out_of(input int i);
        return (i == 0) ? out_a : {{((MA - MB) * DW){1'b0}}, out_b};
    endfunction

    // One complete layer on instance i; optional start held high and spurious done while waiting for weights.
    task automatic run_layer(input int i, input int mm, input int l, input bit hold, input bit spur_wait);
        logic [NW-1:0]    cap;
        logic [MA*DW-1:0] exp_out;
        int               a0, v0, w0, s0, d0, cyc, limit, av;
        bit               seen;
        lat[i] = l;
        for (int k = 0; k < mm; k++) wmem[i][k] = $urandom;
        in_vec  = $urandom;
        cap     = in_vec;
        exp_out = '0;
        for (int k = 0; k < mm; k++) exp_out[k*DW +: DW] = relu(rtab[i][k]);
        a0 = addr_q.size();
        v0 = wv_q.size();
        w0 = wrd_cnt[i];
        s0 = st_cnt[i];
        d0 = done_cnt[i];
        limit    = mm * (5 + l) + 20;
        start[i] = 1'b1;
        cyc      = 0;
        seen     = 1'b0;
        while (!seen && cyc < limit) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (!hold) start[i] = 1'b0;
            if (cyc == 1) in_vec = $urandom;
            spur[i] = spur_wait && (cyc == 2);
            seen    = done[i];
        end
        spur[i] = 1'b0;
        check_output($sformatf("done_seen%0d", i), 64'(seen), 64'd1);
        check_output($sformatf("latency%0d", i), 64'(cyc), 64'(mm * (5 + l) + 1));
        check_output($sformatf("nrn_starts%0d", i), 64'(st_cnt[i] - s0), 64'(mm));
        check_output($sformatf("w_reads%0d", i), 64'(wrd_cnt[i] - w0), 64'(mm));
        for (int k = 0; k < mm; k++) begin
            av = (a0 + k < addr_q.size()) ? addr_q[a0 + k] : -1;
            check_output($sformatf("w_addr%0d_%0d", i, k), 64'(av), 64'(k));
            check_output($sformatf("w_vec%0d_%0d", i, k), 64'(wv_q[v0 + k]), 64'(wmem[i][k]));
            check_output($sformatf("in_vec%0d_%0d", i, k), 64'(iv_q[v0 + k]), 64'(cap));
        end
        check_output($sformatf("out_vec%0d", i), 64'(out_of(i)), 64'(exp_out));
        @(negedge clk);
        check_output($sformatf("done_pulse_one%0d", i), 64'(done[i]), 64'd0);
        check_output($sformatf("done_count%0d", i), 64'(done_cnt[i] - d0), 64'd1);
        check_output($sformatf("idle_after_done%0d", i), 64'(busy[i]), 64'd0);
        if (hold) begin
            @(negedge clk);
            check_output("held_start_reaccept", 64'(busy[i]), 64'd1);
            start[i] = 1'b0;
            cyc  = 0;
            seen = 1'b0;
            while (!seen && cyc < limit) begin
                @(negedge clk);
                cyc++;
                seen = done[i];
            end
            check_output("held_second_done", 64'(seen), 64'd1);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check_output($sformatf("out_hold%0d", i), 64'(out_of(i)), 64'(exp_out));
    endtask

    initial begin
        int s0, d0, cyc, ii, mm;
        rst    = 1'b1;
        start  = 2'b00;
        spur   = 2'b00;
        in_vec = '0;
        lat    = '{1, 1};
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < MA; k++) begin
                wmem[i][k] = '0;
                rtab[i][k] = '0;
            end
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_output($sformatf("rst_busy%0d", i), 64'(busy[i]), 64'd0);
            check_output($sformatf("rst_done%0d", i), 64'(done[i]), 64'd0);
            check_output($sformatf("rst_w_rd%0d", i), 64'(w_rd[i]), 64'd0);
            check_output($sformatf("rst_w_addr%0d", i), 64'(w_addr[i]), 64'd0);
            check_output($sformatf("rst_nrn_start%0d", i), 64'(nrn_start[i]), 64'd0);
            check_output($sformatf("rst_nrn_in%0d", i), 64'(nrn_in_vec[i]), 64'd0);
            check_output($sformatf("rst_nrn_w%0d", i), 64'(nrn_w_vec[i]), 64'd0);
            check_output($sformatf("rst_out%0d", i), 64'(out_of(i)), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        d0 = done_cnt[0];
        spur[0] = 1'b1;
        @(negedge clk);
        spur[0] = 1'b0;
        check_output("idle_spur_busy", 64'(busy[0]), 64'd0);
        check_output("idle_spur_w_rd", 64'(w_rd[0]), 64'd0);
        @(negedge clk);
        check_output("idle_spur_no_done", 64'(done_cnt[0] - d0), 64'd0);

        rtab[0] = '{8'h11, 8'h22, 8'h33};
        run_layer(0, MA, 4, 1'b0, 1'b1);
        check_output("out_332211", 64'(out_a), 64'h332211);

        rtab[1][0] = DW'($urandom);
        run_layer(1, MB, 1, 1'b0, 1'b0);

        for (int k = 0; k < MA; k++) rtab[0][k] = DW'($urandom);
        run_layer(0, MA, 2, 1'b1, 1'b0);

        rtab[0][0] = 8'h5A;
        lat[0]     = 4;
        in_vec     = $urandom;
        s0         = st_cnt[0];
        d0         = done_cnt[0];
        start[0]   = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cyc = 0;
        while ((st_cnt[0] - s0) < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_output("reach_run_nrn1", 64'(st_cnt[0] - s0), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        check_output("midrst_busy", 64'(busy[0]), 64'd0);
        check_output("midrst_out", 64'(out_a), 64'd0);
        check_output("midrst_nrn_in", 64'(nrn_in_vec[0]), 64'd0);
        check_output("midrst_nrn_w", 64'(nrn_w_vec[0]), 64'd0);
        check_output("midrst_nrn_start", 64'(nrn_start[0]), 64'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_output("midrst_no_done", 64'(done_cnt[0] - d0), 64'd0);
        check_output("midrst_idle", 64'(busy[0]), 64'd0);
        run_layer(0, MA, 3, 1'b0, 1'b1);

        rtab[0] = '{8'hF0, 8'h7F, 8'h80};
        run_layer(0, MA, 2, 1'b0, 1'b0);
        check_output("relu_F0", 64'(out_a[DW-1:0]), 64'(F0_STORED));

        for (int r = 0; r < 6; r++) begin
            ii = r % 2;
            mm = (ii == 0) ? MA : MB;
            for (int k = 0; k < mm; k++) rtab[ii][k] = DW'($urandom);
            run_layer(ii, mm, int'($urandom_range(1, 6)), 1'b0, (r % 3) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
